// File: rtl/morse_symbol_sequencer.sv
// Morse element sequencer: times key marks/spaces against a tick base, builds the
// dit/dah pattern of one character and strobes it (and end of word) to the decoder.
//   state    | meaning
//   IDLE     | between words, nothing pending
//   MARK     | key down, timing the current element
//   GAP      | key up inside a character
//   CHARDONE | character emitted, timing towards a word gap
module morse_symbol_sequencer #(
    parameter int MAX_LEN  = 6,
    parameter int LEN_W    = 3,
    parameter int CNT_W    = 8,
    parameter int DAH_MIN  = 2,
    parameter int CHAR_GAP = 3,
    parameter int WORD_GAP = 7,
    parameter int MARK_MAX = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               key,
    output logic [MAX_LEN-1:0] dits_dahs,
    output logic [LEN_W-1:0]   len,
    output logic               word_end,
    output logic               error_out,
    output logic               ce_out,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MARK     = 2'd1,
        S_GAP      = 2'd2,
        S_CHARDONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAX_LEN-1:0] dd_q, dd_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               perr_q, perr_d;
    logic               ce_q, ce_d;
    logic               we_q, we_d;
    logic               eo_q, eo_d;

    logic cnt_sat, mark_hit, char_hit, word_hit, is_dah, len_full;

    // A threshold is "reached" on the tick that would move cnt onto it.
    assign cnt_sat  = (cnt_q == {CNT_W{1'b1}});
    assign mark_hit = tick && (cnt_q == CNT_W'(MARK_MAX - 1));
    assign char_hit = tick && (cnt_q == CNT_W'(CHAR_GAP - 1));
    assign word_hit = tick && (cnt_q == CNT_W'(WORD_GAP - 1));
    assign is_dah   = (cnt_q >= CNT_W'(DAH_MIN));
    assign len_full = (len_q == LEN_W'(MAX_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dd_q    <= '0;
            len_q   <= '0;
            perr_q  <= 1'b0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            eo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dd_q    <= dd_d;
            len_q   <= len_d;
            perr_q  <= perr_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            eo_q    <= eo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dd_d    = dd_q;
        len_d   = len_q;
        perr_d  = perr_q;
        ce_d    = 1'b0;
        we_d    = 1'b0;
        eo_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (key) begin
                    state_d = S_MARK;
                    dd_d    = '0;
                    len_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            S_MARK: begin
                if (!key) begin
                    state_d = S_GAP;
                    if (len_full) begin
                        perr_d = 1'b1;
                    end else begin
                        dd_d  = {dd_q[MAX_LEN-2:0], is_dah};
                        len_d = len_q + LEN_W'(1);
                    end
                end else if (mark_hit) begin
                    perr_d = 1'b1;
                end
            end
            S_GAP: begin
                if (key) begin
                    state_d = S_MARK;
                end else if (char_hit) begin
                    state_d = S_CHARDONE;
                    ce_d    = 1'b1;
                    eo_d    = perr_q;
                end
            end
            S_CHARDONE: begin
                if (key) begin
                    state_d = S_MARK;
                    dd_d    = '0;
                    len_d   = '0;
                    perr_d  = 1'b0;
                end else if (word_hit) begin
                    state_d = S_IDLE;
                    ce_d    = 1'b1;
                    we_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && (state_q != S_IDLE) && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        ce_out    = ce_q;
        word_end  = we_q;
        error_out = eo_q;
        dits_dahs = dd_q;
        len       = len_q;
    end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus random keying,
// all compared every cycle against a run-length model of the keying rules.
module tb_morse_symbol_sequencer;

    localparam int MAX_LEN  = 6;
    localparam int DAH_MIN  = 2;
    localparam int CHAR_GAP = 3;
    localparam int WORD_GAP = 7;
    localparam int MARK_MAX = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       key = 1'b0;
    logic [5:0] dits_dahs;
    logic [2:0] len;
    logic       word_end, error_out, ce_out, busy;

    int n_chk = 0;
    int n_pass = 0;

    morse_symbol_sequencer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key(key),
        .dits_dahs(dits_dahs), .len(len), .word_end(word_end),
        .error_out(error_out), .ce_out(ce_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: activity 0 = silent, 1 = key down, 2 = silence inside character,
    // 3 = silence after an emitted character. m_run counts ticks in the current run.
    int m_act = 0;
    int m_run = 0;
    bit m_elems[$];
    bit m_err = 0;
    bit e_ce = 0, e_we = 0, e_eo = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_run = 0; m_elems.delete(); m_err = 0;
            e_ce = 0; e_we = 0; e_eo = 0;
        end else begin
            e_ce = 0; e_we = 0; e_eo = 0;
            if (m_act == 0) begin
                if (key) begin m_act = 1; m_run = 0; m_elems.delete(); m_err = 0; end
            end else if (m_act == 1) begin
                if (!key) begin
                    if (m_elems.size() == MAX_LEN) m_err = 1;
                    else m_elems.push_back(m_run >= DAH_MIN);
                    m_act = 2; m_run = 0;
                end else if (tick && m_run < 255) begin
                    m_run++;
                    if (m_run == MARK_MAX) m_err = 1;
                end
            end else if (m_act == 2) begin
                if (key) begin m_act = 1; m_run = 0; end
                else if (tick && m_run < 255) begin
                    m_run++;
                    if (m_run == CHAR_GAP) begin
                        m_act = 3; m_run = 0; e_ce = 1; e_eo = m_err;
                    end
                end
            end else begin
                if (key) begin m_act = 1; m_run = 0; m_elems.delete(); m_err = 0; end
                else if (tick && m_run < 255) begin
                    m_run++;
                    if (m_run == WORD_GAP) begin
                        m_act = 0; m_run = 0; e_ce = 1; e_we = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] exp_dd;
        logic [2:0] exp_len;
        exp_dd = '0;
        for (int i = 0; i < m_elems.size(); i++) exp_dd[i] = m_elems[m_elems.size()-1-i];
        exp_len = 3'(m_elems.size());
        n_chk++;
        if ({dits_dahs, len, word_end, error_out, ce_out, busy} ===
            {exp_dd, exp_len, e_we, e_eo, e_ce, (m_act != 0)})
            n_pass++;
        else
            $display("FAIL cycle_cmp t=%0t got dd=%b len=%0d we=%b eo=%b ce=%b busy=%b want dd=%b len=%0d we=%b eo=%b ce=%b busy=%b",
                     $time, dits_dahs, len, word_end, error_out, ce_out, busy,
                     exp_dd, exp_len, e_we, e_eo, e_ce, (m_act != 0));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, act, exp);
    endtask

    task automatic step(input logic k, input logic t);
        key = k; tick = t;
        @(posedge clk); #1;
    endtask

    // Steps with key up and tick every clk until ce_out shows; returns steps taken.
    task automatic wait_ce(input int budget, output int steps);
        steps = 0;
        do begin
            step(1'b0, 1'b1);
            steps++;
        end while (!ce_out && steps < budget);
        if (!ce_out) begin
            steps = -1;
            chk("ce_timeout", 0, 1);
        end
    endtask

    task automatic settle();
        repeat (20) step(1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ce_seen;
        logic k;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {dits_dahs, len, word_end, error_out, ce_out, busy}, 0);
        rst_n = 1'b1;
        step(1'b0, 1'b1);

        // dit, then dah of three ticks, then silence
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        wait_ce(20, n);
        chk("char_gap_steps", n, 3);
        chk("char_dd", dits_dahs, 6'b000001);
        chk("char_len", len, 2);
        chk("char_we", word_end, 0);
        chk("char_eo", error_out, 0);
        wait_ce(20, n);
        chk("word_gap_steps", n, 7);
        chk("word_we", word_end, 1);
        chk("word_eo", error_out, 0);
        step(1'b0, 1'b1);
        chk("ce_one_cycle", ce_out, 0);

        // seven dits overflow a six-element character
        repeat (7) begin step(1'b1, 1'b1); step(1'b0, 1'b1); end
        wait_ce(20, n);
        chk("ovf_len", len, 6);
        chk("ovf_dd", dits_dahs, 0);
        chk("ovf_eo", error_out, 1);
        settle();

        // stuck key
        repeat (12) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        wait_ce(20, n);
        chk("stuck_len", len, 1);
        chk("stuck_dd", dits_dahs, 6'b000001);
        chk("stuck_eo", error_out, 1);
        settle();

        // key returns on the tick that would complete the word gap
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        wait_ce(20, n);
        repeat (6) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("late_key_ce", ce_out, 0);
        chk("late_key_len", len, 0);
        chk("late_key_busy", busy, 1);
        settle();

        // reset during a mark of the third element
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("pre_reset_len", len, 2);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {dits_dahs, len, word_end, error_out, ce_out, busy}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        ce_seen = 0;
        repeat (20) begin step(1'b0, 1'b1); ce_seen += int'(ce_out); end
        chk("post_reset_no_ce", ce_seen, 0);

        // tick stalled inside a gap
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        ce_seen = 0;
        repeat (50) begin step(1'b0, 1'b0); ce_seen += int'(ce_out); end
        chk("stall_no_ce", ce_seen, 0);
        chk("stall_busy", busy, 1);
        chk("stall_cnt", int'(dut.cnt_q), 1);
        wait_ce(20, n);
        chk("stall_resume_steps", n, 2);
        settle();

        // random keying with a sparse tick and occasional reset
        k = 1'b0;
        for (int r = 0; r < 400; r++) begin
            k = ($urandom_range(0, 4) == 0) ? k : ~k;
            n = (k == 1'b0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                                        : int'($urandom_range(1, 13));
            for (int j = 0; j < n; j++) step(k, ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                step(k, 1'b1);
                rst_n = 1'b1;
            end
        end
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
